// File: rtl/bin_bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r++;
    end
    return r;
  endfunction

  // Decimal digits needed for the largest BIN_W-bit unsigned value.
  function automatic int min_digits(input int bin_w);
    longint unsigned v;
    int n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, with
// valid/ready handshakes, optional two's-complement input and overflow reporting.
module bin_to_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 13,
  parameter int DIGITS = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [BIN_W-1:0]                 i_binary_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [DIGITS*DIGIT_W-1:0]        o_bcd_data,
  output logic                             o_sign,
  output logic [clog2(DIGITS+1)-1:0]       o_ndig,
  output logic                             o_overflow
);

  localparam int BCD_W  = DIGITS * DIGIT_W;
  localparam int NDIG_W = clog2(DIGITS + 1);
  localparam int CNT_W  = clog2(BIN_W + 1);
  // When enough digits exist for any input, the top carry can never be set.
  localparam bit OVF_POSSIBLE = (DIGITS < min_digits(BIN_W));

  if (BIN_W < 2 || BIN_W > 32 || DIGITS < 1 || DIGITS > 10) begin : g_param_check
    $fatal(1, "bin_to_bcd_seq: BIN_W must be 2..32 and DIGITS 1..10");
  end

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   digits;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt;
  logic               sign_r;
  logic               ovf_r;

  logic               in_neg;
  logic [BIN_W-1:0]   mag;
  logic               carry;
  logic [BCD_W-1:0]   digits_sh;
  logic [BIN_W-1:0]   shreg_sh;
  logic               ovf_nxt;
  logic               last_step;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (digits[g*DIGIT_W +: DIGIT_W]),
      .o_digit (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  function automatic logic [NDIG_W-1:0] calc_ndig(input logic [BCD_W-1:0] d, input logic ovf);
    logic [NDIG_W-1:0] n;
    n = NDIG_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (d[i*DIGIT_W +: DIGIT_W] != 4'd0) n = NDIG_W'(i + 1);
    end
    if (ovf) n = NDIG_W'(DIGITS);
    return n;
  endfunction

  // Negation in BIN_W bits maps -2^(BIN_W-1) onto its correct unsigned magnitude.
  assign in_neg    = SIGNED && i_binary_data[BIN_W-1];
  assign mag       = in_neg ? (~i_binary_data + BIN_W'(1)) : i_binary_data;
  assign carry     = adj[BCD_W-1];
  assign digits_sh = {adj[BCD_W-2:0], shreg[BIN_W-1]};
  assign shreg_sh  = {shreg[BIN_W-2:0], 1'b0};
  assign ovf_nxt   = OVF_POSSIBLE && (ovf_r || carry);
  assign last_step = (cnt == CNT_W'(BIN_W - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)   state_nxt = CONV;
      CONV:    if (last_step) state_nxt = DONE;
      DONE:    if (i_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shreg      <= '0;
      digits     <= '0;
      cnt        <= '0;
      sign_r     <= 1'b0;
      ovf_r      <= 1'b0;
      o_bcd_data <= '0;
      o_sign     <= 1'b0;
      o_ndig     <= NDIG_W'(1);
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            shreg  <= mag;
            sign_r <= in_neg;
            digits <= '0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
          end
        end
        CONV: begin
          shreg  <= shreg_sh;
          digits <= digits_sh;
          ovf_r  <= ovf_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            o_bcd_data <= digits_sh;
            o_sign     <= sign_r;
            o_overflow <= ovf_nxt;
            o_ndig     <= calc_ndig(digits_sh, ovf_nxt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using double-dabble, one shift step per clock. It replaces the fixed 13-bit/4-digit converter with the following:
- configurable input width and digit count
- optional two's-complement input
- valid/ready handshakes on both sides
- significant-digit count and overflow outputs

It sits between arithmetic datapaths and display/UART formatters.

Parameters:
BIN_W, 13, input binary width in bits (2..32).
DIGITS, 4, number of BCD output digits (1..10).
SIGNED, 0, 1 = input is two's complement; magnitude is converted and sign reported separately.

Ports:
i_clk  in  1  system clock, rising edge.
i_reset_n  in  1  reset, asynchronous assert, active-low.
i_valid  in  1  input word valid.
o_ready  out  1  converter idle, can accept input.
i_binary_data  in  BIN_W  binary input.
o_valid  out  1  result valid, held until accepted.
i_ready  in  1  downstream accepts result.
o_bcd_data  out  4*DIGITS  packed BCD, digit 0 (units) in [3:0].
o_sign  out  1  1 = negative input (SIGNED=1 only, else 0).
o_ndig  out  clog2(DIGITS+1)  count of significant digits, minimum 1.
o_overflow  out  1  value not representable in DIGITS digits.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset state, applied immediately on i_reset_n low:
  - state IDLE, o_ready=1, o_valid=0
  - o_bcd_data=0, o_sign=0, o_ndig=1, o_overflow=0
  - internal shift/count registers = 0
- Reset mid-conversion aborts the conversion with no output.
- States: IDLE, CONV, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready edge: latch the magnitude into the shift register, latch sign, clear the digit registers and overflow flag, counter=0, go to CONV.
  - Magnitude for SIGNED=1 with MSB set: two's-complement negation in BIN_W bits, unsigned interpretation, so -2^(BIN_W-1) converts correctly.
  - Input is ignored while o_ready=0.
- CONV, one step per cycle:
  - Every digit >=5 gets +3 (combinational correction).
  - Then shift {digits, shreg} left by 1.
  - A bit shifted out of the top digit sets sticky overflow.
  - Counter increments; after step BIN_W-1 (BIN_W steps total) go to DONE.
  - Output registers load on that same edge: o_bcd_data, o_sign, o_overflow, o_ndig.
  - o_ndig = index of the highest nonzero digit + 1; all-zero gives 1.
- DONE:
  - o_valid=1, outputs stable.
  - On i_ready go to IDLE (o_valid=0 next cycle).
  - With i_ready low, hold indefinitely.
- Latency: o_valid rises BIN_W cycles after the accepting edge.
- Throughput: one word per BIN_W+2 cycles with i_ready tied high.
- o_ready and o_valid are never high together.
- Overflow result: o_bcd_data holds the low DIGITS digits (value mod 10^DIGITS), o_ndig=DIGITS.
- Elaboration check: BIN_W and DIGITS out of range is a fatal error. DIGITS < ceil(BIN_W*log10(2)) is legal (overflow possible).

Decomposition:
- Package bin_bcd_pkg:
  - state enum (IDLE, CONV, DONE)
  - clog2 function
  - function min_digits(BIN_W), for the elaboration check and testbench
  - BCD digit width constant 4
- Sub-module bcd_digit_adj: combinational 4-bit add-3-if-≥5 cell, instantiated DIGITS times via generate.

Test Plan:
- Default params, i_binary_data=8191, i_ready=1 -> o_valid exactly 13 cycles after accept; o_bcd_data=16'h8191, o_ndig=4, o_overflow=0.
- Default params, input 0 then 7 back-to-back (i_valid held) -> results 16'h0000/ndig=1, then 16'h0007/ndig=1; second accept occurs 15 cycles after the first.
- SIGNED=1, BIN_W=8, DIGITS=3, input 8'h80 -> o_sign=1, o_bcd_data=12'h128, o_ndig=3; input 8'hFF -> o_sign=1, 12'h001, ndig=1.
- DIGITS=3, BIN_W=13, input 1234 -> o_overflow=1, o_bcd_data=12'h234, o_ndig=3.
- Backpressure: i_ready=0 for 20 cycles after o_valid -> outputs stable, o_ready=0, new i_valid ignored; i_ready pulse -> o_valid drops next cycle, o_ready=1.
- Reset: assert i_reset_n=0 mid-CONV (step 5) asynchronously -> outputs at reset values before the next edge; after release, input 4095 -> 16'h4095.
